// File: rtl/imem_loader.sv
// Sequential program loader: receives a length-prefixed, XOR-checksummed byte
// frame and writes its payload into instruction memory while holding the CPU.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_wEn,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] bytes_written
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [7:0]       csum;

    logic             accept_c;
    logic [LEN_W-1:0] len_full_c;
    logic             oversize_c;
    logic             last_c;

    // Handshake decode and length/bound checks on the byte being accepted.
    always_comb begin
        accept_c   = in_valid && in_ready;
        len_full_c = {in_byte, len[7:0]};
        oversize_c = (ADDR_W'(BASE_ADDR) + ADDR_W'(len_full_c)) > ADDR_W'(MEM_BYTES);
        last_c     = (bytes_written + LEN_W'(1)) == len;
    end

    // Frame FSM; in_ready is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            mem_wEn       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            bytes_written <= '0;
            len           <= '0;
            csum          <= '0;
        end else begin
            mem_wEn <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state         <= S_LEN_LO;
                        in_ready      <= 1'b1;
                        done          <= 1'b0;
                        err           <= 1'b0;
                        bytes_written <= '0;
                        csum          <= '0;
                        cpu_hold      <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (accept_c) begin
                        len[7:0] <= in_byte;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept_c) begin
                        len <= len_full_c;
                        if (oversize_c) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else if (len_full_c == '0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_c) begin
                        mem_wEn       <= 1'b1;
                        mem_addr      <= ADDR_W'(BASE_ADDR) + ADDR_W'(bytes_written);
                        mem_wdata     <= in_byte;
                        csum          <= csum ^ in_byte;
                        bytes_written <= bytes_written + LEN_W'(1);
                        if (last_c) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept_c) begin
                        in_ready <= 1'b0;
                        if (in_byte == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
